// File: rtl/mux_pkg.sv
// mux_pkg: shared helpers for the mux family
package mux_pkg;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-then-priority-encode round-robin grant, purely combinational
module rr_pick import mux_pkg::*; #(
  parameter int NCH = 4,
  localparam int SELW = idx_w(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt,
  output logic            gnt_valid
);
  // scan farthest-first so the nearest requester after ptr wins
  always_comb begin
    gnt = '0;
    gnt_valid = 1'b0;
    for (int i = NCH; i >= 1; i--)
      if (req[SELW'((int'(ptr) + i) % NCH)]) begin
        gnt = SELW'((int'(ptr) + i) % NCH);
        gnt_valid = 1'b1;
      end
  end
endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N:1 valid/ready mux with registered output, fixed or round-robin select
module rr_arb_mux import mux_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int NCH = 4,
  localparam int SELW = idx_w(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);
  logic [SELW-1:0] ptr, rr_gnt, gnt;
  logic rr_valid, fx_valid, gnt_valid, load_en;
  rr_pick #(.NCH(NCH)) u_pick (
    .req(in_valid),
    .ptr(ptr),
    .gnt(rr_gnt),
    .gnt_valid(rr_valid)
  );
  assign fx_valid = (32'(sel) < NCH) && in_valid[sel];
  assign gnt = mode ? rr_gnt : sel;
  assign gnt_valid = mode ? rr_valid : fx_valid;
  assign load_en = !out_valid || out_ready;
  assign in_ready = (!rst && load_en && gnt_valid) ? NCH'(1) << gnt : '0;
  always_ff @(posedge clk)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      ptr <= SELW'(NCH - 1);
    end else if (load_en) begin
      out_valid <= gnt_valid;
      if (gnt_valid) begin
        out_data <= in_data[gnt*WIDTH +: WIDTH];
        out_chan <= gnt;
        if (mode) ptr <= gnt;
      end
    end
endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N:1 channel multiplexer with a registered output and a valid/ready handshake on every channel.
- Two selection modes:
  - fixed: an external select picks the channel, as in the existing combinational mux.
  - round-robin: the block arbitrates fairly among the requesting channels.
- Sits between several producer blocks and one shared consumer; replaces the bare 4:1 mux wherever flow control or fairness is needed.

Parameters:
- WIDTH, 8, data bits per channel.
- NCH, 4, number of input channels; must be at least 2.
- SELW, $clog2(NCH), channel index width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used when mode=0.
- in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; combinational.
- out_data  output  WIDTH  registered data.
- out_chan  output  SELW  registered index of the source channel.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset, on a clk edge with rst=1: out_valid=0, out_data=0, out_chan=0, round-robin pointer ptr=NCH-1 (so channel 0 has first priority). All in_ready are 0 while rst=1.
- load_en = !out_valid || out_ready. The output register accepts a new word when it is empty or is being drained in the same cycle.
- Grant in fixed mode (mode=0):
  - gnt_valid = (sel < NCH) && in_valid[sel]; gnt = sel.
  - sel >= NCH yields no grant.
  - Invalid channels are never substituted.
- Grant in round-robin mode (mode=1):
  - Search channels ptr+1, ptr+2, ... modulo NCH.
  - The first channel with in_valid=1 is gnt; gnt_valid=1 if any in_valid is set.
- in_ready[k] = !rst && load_en && gnt_valid && (gnt==k). At most one in_ready is high in any cycle.
- Transfer on channel k when in_valid[k] && in_ready[k]. On the next edge: out_data <= channel k data, out_chan <= k, out_valid <= 1. Latency is one cycle from input acceptance to out_valid.
- If load_en=1 and there is no grant, out_valid <= 0 on the next edge. If load_en=0, all output registers hold.
- Pointer:
  - ptr <= gnt only on a transfer while mode=1.
  - ptr holds in fixed mode and on cycles with no transfer.
  - Wrap: after a grant to NCH-1, the search starts at channel 0.
- Sustained throughput is one word per cycle when out_ready stays 1. in_ready has a combinational path from out_ready; there is no skid buffer.
- Fairness: with all channels continuously valid in round-robin mode, grants cycle 0,1,...,NCH-1,0,... Each channel waits at most NCH-1 transfers.
- Mode change takes effect in the same cycle (grant logic is combinational). ptr keeps its value across mode changes.
- Input stability: data on a valid channel with no grant must be held by its producer. The block does not capture it.
- rst asserted mid-transfer discards the held word, with no output handshake. Any input transfer in that cycle is suppressed because in_ready=0.
- Simultaneous drain and load, with out_valid=1, out_ready=1 and a grant: the old word leaves and the new word loads on the same edge. There is no bubble.

Decomposition:
- Shared package mux_pkg holds the function to compute the index width (wrapper over $clog2, minimum 1), shared by this block and future mux variants.
- One natural sub-module, rr_pick, is purely combinational:
  - Inputs: req[NCH], ptr[SELW].
  - Outputs: gnt[SELW], gnt_valid. It performs the rotate-then-priority-encode.
- rr_arb_mux instantiates rr_pick and muxes its result against the fixed-select path.

Test Plan:
1. Reset, then fixed-mode basic (NCH=4, WIDTH=8):
   - Stimulus: rst held 2 cycles, then mode=0, sel=2, in_valid=4'b0100, ch2=8'hA5, out_ready=1.
   - Response: in_ready=4'b0100 at once; the next cycle out_valid=1, out_data=A5, out_chan=2.
   - Also with sel=2 and in_valid=4'b1011: in_ready=0 and out_valid falls to 0.
2. Round-robin fairness:
   - Stimulus: mode=1, in_valid=4'b1111, ch k data = 8'h10+k, out_ready=1 for 8 cycles.
   - Response: out_chan sequence 0,1,2,3,0,1,2,3 with matching data and no bubbles.
3. Sparse round-robin:
   - Stimulus: in_valid=4'b1010 continuously.
   - Response: grants alternate 1,3,1,3. Channels 0 and 2 never see in_ready.
4. Backpressure:
   - Stimulus: output holds 8'h11; out_ready=0 for 3 cycles while ch0 is valid.
   - Response: out_data stays 11, out_valid=1, in_ready=0. On out_ready=1, ch0 is accepted and appears the next cycle.
5. Mode switch and reset mid-operation:
   - Stimulus: the last round-robin grant was ch1, so ptr=1; switch to mode=0, sel=0 for 2 transfers, then back to mode=1 with all valid.
   - Response: the next round-robin grant is ch2, since ptr was held.
   - Then assert rst while out_valid=1. Response: out_valid=0 and in_ready=0 in that cycle; after release, the first round-robin grant is ch0.
6. Parameter sweep:
   - Stimulus: repeat scenario 2 with NCH=3, WIDTH=16.
   - Response: wrap sequence 0,1,2,0. sel=3 in fixed mode produces no grant.
